input_capture_manager: RTL

Memory-mapped input block for the z8 core, carrying data in the opposite direction to the hex-display output path. It synchronises and debounces the board switches (SW) and push-buttons (KEY) and latches key-press events. It presents them as four read-only byte registers that memory_manager reads on behalf of the CPU. Event flags are sticky and cleared on read, so a program polling in a loop never misses a press.

---
 rtl/input_capture_manager_pkg.sv | 23 ++
 rtl/input_debouncer.sv | 48 ++++
 rtl/input_capture_manager.sv | 93 +++++++++
 3 files changed

// File: rtl/input_capture_manager_pkg.sv
// Shared definitions for the memory-mapped board input block: register map,
// input counts and the read-port data width.
package input_capture_manager_pkg;

  localparam int WORD_SIZE = 8;
  localparam int NUM_SW    = 10;
  localparam int NUM_KEY   = 4;

  // Read-only byte registers seen by memory_manager.
  typedef enum logic [1:0] {
    IO_SW_LO   = 2'd0,
    IO_SW_HI   = 2'd1,
    IO_KEY_LVL = 2'd2,
    IO_KEY_EVT = 2'd3
  } IO_REG_T;

  // One read request as sampled on a clock edge.
  typedef struct packed {
    logic    en;
    IO_REG_T addr;
  } rd_req_t;

endpackage

// File: rtl/input_debouncer.sv
// One-bit 2-FF synchroniser plus debouncer. The stable level only moves after
// DEBOUNCE_CYCLES consecutive synced samples disagree with it; any sample that
// agrees restarts the count. flip is high in the cycle whose edge moves level.
module input_debouncer #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic flip
);

  localparam int             CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          synced;
  logic          diff;

  assign synced = sync[1];
  assign diff   = synced ^ level;
  assign flip   = diff && (cnt == LAST);

  // Metastability guard: reset to the idle level so no phantom edge on release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= {2{RESET_LEVEL}};
    else        sync <= {sync[0], din};
  end

  // Qualify a change: count disagreeing samples, commit on the last one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= RESET_LEVEL;
      cnt   <= '0;
    end else if (!diff) begin
      cnt   <= '0;
    end else if (cnt == LAST) begin
      level <= synced;
      cnt   <= '0;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/input_capture_manager.sv
// Board input block: debounced switches and keys, sticky clear-on-read
// key-press flags, and a registered 1-cycle-latency read port.
module input_capture_manager
  import input_capture_manager_pkg::*;
#(
  parameter int WORD_SIZE       = input_capture_manager_pkg::WORD_SIZE,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SW-1:0]    SW,
  input  logic [NUM_KEY-1:0]   KEY,
  input  logic                 rd_en,
  input  logic [1:0]           rd_addr,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 key_event_pending
);

  logic [NUM_SW-1:0]    sw_level;
  logic [NUM_SW-1:0]    sw_flip_unused;
  logic [NUM_KEY-1:0]   key_stable;   // raw polarity: 1 = released
  logic [NUM_KEY-1:0]   key_flip;
  logic [NUM_KEY-1:0]   key_level;    // 1 = pressed
  logic [NUM_KEY-1:0]   new_evt;
  logic [NUM_KEY-1:0]   returned;
  logic [NUM_KEY-1:0]   key_flags;
  logic [NUM_KEY-1:0]   key_flags_nxt;
  logic [WORD_SIZE-1:0] rd_mux;
  rd_req_t              req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
      input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_db (
        .clk(clk), .reset(reset), .din(SW[gi]),
        .level(sw_level[gi]), .flip(sw_flip_unused[gi])
      );
    end
    for (gi = 0; gi < NUM_KEY; gi++) begin : g_key
      input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_db (
        .clk(clk), .reset(reset), .din(KEY[gi]),
        .level(key_stable[gi]), .flip(key_flip[gi])
      );
    end
  endgenerate

  assign req       = '{en: rd_en, addr: IO_REG_T'(rd_addr)};
  assign key_level = ~key_stable;

  // A key leaving the released state on this edge is a press.
  assign new_evt  = key_flip & key_stable;

  // Only the flags actually returned are cleared, so a press landing on the
  // read edge survives for the next read.
  assign returned      = (req.en && req.addr == IO_KEY_EVT) ? key_flags : '0;
  assign key_flags_nxt = (key_flags & ~returned) | new_evt;

  // Register map read mux; unlisted upper bits read 0.
  always_comb begin
    rd_mux = '0;
    unique case (req.addr)
      IO_SW_LO:   rd_mux = WORD_SIZE'(sw_level[7:0]);
      IO_SW_HI:   rd_mux = WORD_SIZE'(sw_level[9:8]);
      IO_KEY_LVL: rd_mux = WORD_SIZE'(key_level);
      IO_KEY_EVT: rd_mux = WORD_SIZE'(key_flags);
      default:    rd_mux = '0;
    endcase
  end

  // Sticky event flags and their registered summary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_flags         <= '0;
      key_event_pending <= 1'b0;
    end else begin
      key_flags         <= key_flags_nxt;
      key_event_pending <= |key_flags_nxt;
    end
  end

  // Read port: data holds between reads, valid pulses once per read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= req.en;
      if (req.en) rd_data <= rd_mux;
    end
  end

endmodule
